// File: rtl/riscv_pkg.sv
// Shared RISC-V datapath types: operand widths and the ALU operation code.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLL  = 4'd2,
        ALU_SRL  = 4'd3,
        ALU_SRA  = 4'd4,
        ALU_AND  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } alu_op_e;

endpackage

// File: rtl/idex_shift_stage_if.sv
// ID/EX boundary bundle: decode handshake and fields, MEM/WB writeback sources, EX handshake and outputs.
interface idex_shift_stage_if;
    import riscv_pkg::*;

    logic                  i_id_valid;
    logic                  o_id_ready;
    logic [XLEN-1:0]       i_id_rs1_data;
    logic [XLEN-1:0]       i_id_rs2_data;
    logic [XLEN-1:0]       i_id_imm;
    logic [REG_ADDR_W-1:0] i_id_rs1_addr;
    logic [REG_ADDR_W-1:0] i_id_rs2_addr;
    logic [REG_ADDR_W-1:0] i_id_rd_addr;
    logic                  i_id_use_imm;
    alu_op_e               i_id_alu_op;

    logic                  i_mem_rd_wren;
    logic [REG_ADDR_W-1:0] i_mem_rd_addr;
    logic [XLEN-1:0]       i_mem_rd_data;
    logic                  i_wb_rd_wren;
    logic [REG_ADDR_W-1:0] i_wb_rd_addr;
    logic [XLEN-1:0]       i_wb_rd_data;

    logic                  i_flush;
    logic                  o_ex_valid;
    logic                  i_ex_ready;
    logic [XLEN-1:0]       o_ex_operand_a;
    logic [XLEN-1:0]       o_ex_operand_b;
    logic [4:0]            o_ex_shamt;
    logic [REG_ADDR_W-1:0] o_ex_rd_addr;
    alu_op_e               o_ex_alu_op;

    modport master (
        output i_id_valid, i_id_rs1_data, i_id_rs2_data, i_id_imm,
               i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr, i_id_use_imm, i_id_alu_op,
               i_mem_rd_wren, i_mem_rd_addr, i_mem_rd_data,
               i_wb_rd_wren, i_wb_rd_addr, i_wb_rd_data,
               i_flush, i_ex_ready,
        input  o_id_ready, o_ex_valid, o_ex_operand_a, o_ex_operand_b,
               o_ex_shamt, o_ex_rd_addr, o_ex_alu_op
    );

    modport slave (
        input  i_id_valid, i_id_rs1_data, i_id_rs2_data, i_id_imm,
               i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr, i_id_use_imm, i_id_alu_op,
               i_mem_rd_wren, i_mem_rd_addr, i_mem_rd_data,
               i_wb_rd_wren, i_wb_rd_addr, i_wb_rd_data,
               i_flush, i_ex_ready,
        output o_id_ready, o_ex_valid, o_ex_operand_a, o_ex_operand_b,
               o_ex_shamt, o_ex_rd_addr, o_ex_alu_op
    );

endinterface

// File: rtl/idex_shift_stage_fwd_sel.sv
// Three-way operand forwarding select: MEM beats WB beats the held register; x0 never forwards.
module fwd_sel
    import riscv_pkg::*;
(
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [XLEN-1:0]       reg_val,
    input  logic                  mem_wren,
    input  logic [REG_ADDR_W-1:0] mem_addr,
    input  logic [XLEN-1:0]       mem_data,
    input  logic                  wb_wren,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    output logic [XLEN-1:0]       val,
    output logic                  hit
);

    logic mem_hit;
    logic wb_hit;

    always_comb begin
        mem_hit = mem_wren && (rs_addr != '0) && (mem_addr == rs_addr);
        wb_hit  = wb_wren  && (rs_addr != '0) && (wb_addr  == rs_addr);
        hit     = mem_hit || wb_hit;
        val     = reg_val;
        if (mem_hit) begin
            val = mem_data;
        end else if (wb_hit) begin
            val = wb_data;
        end
    end

endmodule

// File: rtl/idex_shift_stage.sv
// Single-entry ID/EX pipeline register with operand forwarding and stall refresh.
// Build option: define EX_FWD_EN to enable MEM/WB forwarding; undefined, operands come straight from the held registers.
module idex_shift_stage
    import riscv_pkg::*;
(
    input  logic               i_clk,
    input  logic               i_rst_n,
    idex_shift_stage_if.slave  bus
);

`ifdef EX_FWD_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic                  ex_valid_q, ex_valid_d;
    logic [XLEN-1:0]       opa_q, opa_d;
    logic [XLEN-1:0]       opb_q, opb_d;
    logic [REG_ADDR_W-1:0] rs1_addr_q, rs1_addr_d;
    logic [REG_ADDR_W-1:0] rs2_addr_q, rs2_addr_d;
    logic [REG_ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic                  use_imm_q, use_imm_d;
    alu_op_e               alu_op_q, alu_op_d;

    logic                  id_ready;
    logic                  load;
    logic                  mem_wren_a, wb_wren_a, mem_wren_b, wb_wren_b;
    logic [XLEN-1:0]       fwd_a_val, fwd_b_val;
    logic                  hit_a, hit_b;

    assign id_ready = !ex_valid_q || bus.i_ex_ready;
    assign load     = bus.i_id_valid && id_ready && !bus.i_flush;

    // An immediate in operand B has no register source, so B never forwards then.
    assign mem_wren_a = FWD_EN && bus.i_mem_rd_wren;
    assign wb_wren_a  = FWD_EN && bus.i_wb_rd_wren;
    assign mem_wren_b = mem_wren_a && !use_imm_q;
    assign wb_wren_b  = wb_wren_a  && !use_imm_q;

    fwd_sel u_fwd_a (
        .rs_addr  (rs1_addr_q),
        .reg_val  (opa_q),
        .mem_wren (mem_wren_a),
        .mem_addr (bus.i_mem_rd_addr),
        .mem_data (bus.i_mem_rd_data),
        .wb_wren  (wb_wren_a),
        .wb_addr  (bus.i_wb_rd_addr),
        .wb_data  (bus.i_wb_rd_data),
        .val      (fwd_a_val),
        .hit      (hit_a)
    );

    fwd_sel u_fwd_b (
        .rs_addr  (rs2_addr_q),
        .reg_val  (opb_q),
        .mem_wren (mem_wren_b),
        .mem_addr (bus.i_mem_rd_addr),
        .mem_data (bus.i_mem_rd_data),
        .wb_wren  (wb_wren_b),
        .wb_addr  (bus.i_wb_rd_addr),
        .wb_data  (bus.i_wb_rd_data),
        .val      (fwd_b_val),
        .hit      (hit_b)
    );

    always_comb begin
        ex_valid_d = ex_valid_q;
        opa_d      = opa_q;
        opb_d      = opb_q;
        rs1_addr_d = rs1_addr_q;
        rs2_addr_d = rs2_addr_q;
        rd_addr_d  = rd_addr_q;
        use_imm_d  = use_imm_q;
        alu_op_d   = alu_op_q;
        if (bus.i_flush) begin
            ex_valid_d = 1'b0;
        end else if (load) begin
            ex_valid_d = 1'b1;
            opa_d      = bus.i_id_rs1_data;
            opb_d      = bus.i_id_use_imm ? bus.i_id_imm : bus.i_id_rs2_data;
            rs1_addr_d = bus.i_id_rs1_addr;
            rs2_addr_d = bus.i_id_rs2_addr;
            rd_addr_d  = bus.i_id_rd_addr;
            use_imm_d  = bus.i_id_use_imm;
            alu_op_d   = bus.i_id_alu_op;
        end else if (ex_valid_q && bus.i_ex_ready) begin
            ex_valid_d = 1'b0;
        end else if (ex_valid_q && FWD_EN) begin
            // Stalled: latch any forwarded value so it survives the producer retiring.
            if (hit_a) opa_d = fwd_a_val;
            if (hit_b) opb_d = fwd_b_val;
        end
    end

    // ID -> EX register boundary
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ex_valid_q <= 1'b0;
            opa_q      <= '0;
            opb_q      <= '0;
            rs1_addr_q <= '0;
            rs2_addr_q <= '0;
            rd_addr_q  <= '0;
            use_imm_q  <= 1'b0;
            alu_op_q   <= ALU_ADD;
        end else begin
            ex_valid_q <= ex_valid_d;
            opa_q      <= opa_d;
            opb_q      <= opb_d;
            rs1_addr_q <= rs1_addr_d;
            rs2_addr_q <= rs2_addr_d;
            rd_addr_q  <= rd_addr_d;
            use_imm_q  <= use_imm_d;
            alu_op_q   <= alu_op_d;
        end
    end

    assign bus.o_id_ready     = id_ready;
    assign bus.o_ex_valid     = ex_valid_q;
    assign bus.o_ex_operand_a = fwd_a_val;
    assign bus.o_ex_operand_b = fwd_b_val;
    assign bus.o_ex_shamt     = fwd_b_val[4:0];
    assign bus.o_ex_rd_addr   = rd_addr_q;
    assign bus.o_ex_alu_op    = alu_op_q;

endmodule

// File: tb/tb_idex_shift_stage.sv
// Directed bench for idex_shift_stage; forwarding expectations follow the EX_FWD_EN build option.
module tb_idex_shift_stage;
    import riscv_pkg::*;

`ifdef EX_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic i_clk = 1'b0;
    logic i_rst_n;
    int   n_assert = 0;
    int   n_fail   = 0;

    idex_shift_stage_if bus ();

    idex_shift_stage dut (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .bus     (bus)
    );

    always #5 i_clk = ~i_clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_id_valid    = 1'b0;
        bus.i_id_rs1_data = '0;
        bus.i_id_rs2_data = '0;
        bus.i_id_imm      = '0;
        bus.i_id_rs1_addr = '0;
        bus.i_id_rs2_addr = '0;
        bus.i_id_rd_addr  = '0;
        bus.i_id_use_imm  = 1'b0;
        bus.i_id_alu_op   = ALU_ADD;
        bus.i_mem_rd_wren = 1'b0;
        bus.i_mem_rd_addr = '0;
        bus.i_mem_rd_data = '0;
        bus.i_wb_rd_wren  = 1'b0;
        bus.i_wb_rd_addr  = '0;
        bus.i_wb_rd_data  = '0;
        bus.i_flush       = 1'b0;
        bus.i_ex_ready    = 1'b1;
    endtask

    task automatic present(input logic [4:0] rs1, input logic [31:0] d1,
                           input logic [4:0] rs2, input logic [31:0] d2,
                           input logic [31:0] imm, input logic use_imm,
                           input logic [4:0] rd, input alu_op_e op);
        bus.i_id_valid    = 1'b1;
        bus.i_id_rs1_addr = rs1;
        bus.i_id_rs1_data = d1;
        bus.i_id_rs2_addr = rs2;
        bus.i_id_rs2_data = d2;
        bus.i_id_imm      = imm;
        bus.i_id_use_imm  = use_imm;
        bus.i_id_rd_addr  = rd;
        bus.i_id_alu_op   = op;
    endtask

    initial begin
        idle_inputs();
        // Reset while decode is offering an instruction: reset must win.
        i_rst_n = 1'b0;
        present(5'd9, 32'hDEAD_BEEF, 5'd0, 32'h0, 32'h0, 1'b0, 5'd3, ALU_SUB);
        tick();
        tick();
        check_eq("rst_valid", 32'(bus.o_ex_valid), 32'd0);
        check_eq("rst_opa", bus.o_ex_operand_a, 32'h0);
        check_eq("rst_opb", bus.o_ex_operand_b, 32'h0);
        check_eq("rst_aluop", 32'(bus.o_ex_alu_op), 32'(ALU_ADD));

        i_rst_n = 1'b1;
        idle_inputs();
        #1;
        check_eq("rel_ready", 32'(bus.o_id_ready), 32'd1);

        // Load with immediate operand B; shamt is low bits of B.
        present(5'd5, 32'h0000_0001, 5'd5, 32'h0000_0099, 32'h0000_0004, 1'b1, 5'd7, ALU_SLL);
        tick();
        bus.i_id_valid = 1'b0;
        bus.i_ex_ready = 1'b0;
        #1;
        check_eq("ld_valid", 32'(bus.o_ex_valid), 32'd1);
        check_eq("ld_opa", bus.o_ex_operand_a, 32'h1);
        check_eq("ld_opb", bus.o_ex_operand_b, 32'h4);
        check_eq("ld_shamt", 32'(bus.o_ex_shamt), 32'd4);
        check_eq("ld_rd", 32'(bus.o_ex_rd_addr), 32'd7);
        check_eq("ld_aluop", 32'(bus.o_ex_alu_op), 32'(ALU_SLL));
        check_eq("stall_ready", 32'(bus.o_id_ready), 32'd0);

        // MEM and WB both write r5: MEM wins; B holds an immediate and never forwards.
        bus.i_mem_rd_wren = 1'b1; bus.i_mem_rd_addr = 5'd5; bus.i_mem_rd_data = 32'hAAAA_0000;
        bus.i_wb_rd_wren  = 1'b1; bus.i_wb_rd_addr  = 5'd5; bus.i_wb_rd_data  = 32'h5555_0000;
        #1;
        check_eq("fwd_mem_pri", bus.o_ex_operand_a, FWD ? 32'hAAAA_0000 : 32'h1);
        check_eq("fwd_imm_b", bus.o_ex_operand_b, 32'h4);
        bus.i_mem_rd_wren = 1'b0;
        #1;
        check_eq("fwd_wb", bus.o_ex_operand_a, FWD ? 32'h5555_0000 : 32'h1);
        bus.i_wb_rd_wren = 1'b0;
        bus.i_ex_ready   = 1'b1;
        tick();
        check_eq("consume_valid", 32'(bus.o_ex_valid), 32'd0);

        // rs1 = x0 must not forward; rs2 = r3 from a register does.
        present(5'd0, 32'h0, 5'd3, 32'h0000_0030, 32'h0, 1'b0, 5'd1, ALU_ADD);
        tick();
        bus.i_id_valid = 1'b0;
        bus.i_ex_ready = 1'b0;
        bus.i_mem_rd_wren = 1'b1; bus.i_mem_rd_addr = 5'd0; bus.i_mem_rd_data = 32'hFFFF_FFFF;
        bus.i_wb_rd_wren  = 1'b1; bus.i_wb_rd_addr  = 5'd3; bus.i_wb_rd_data  = 32'h0000_0333;
        #1;
        check_eq("x0_no_fwd", bus.o_ex_operand_a, 32'h0);
        check_eq("fwd_b_reg", bus.o_ex_operand_b, FWD ? 32'h0000_0333 : 32'h30);
        bus.i_mem_rd_wren = 1'b0;
        bus.i_wb_rd_wren  = 1'b0;
        bus.i_ex_ready    = 1'b1;
        tick();

        // Stall refresh: WB hit only in stall cycle 1 must persist.
        present(5'd6, 32'h0000_0011, 5'd0, 32'h0, 32'h0, 1'b1, 5'd2, ALU_SRL);
        tick();
        bus.i_id_valid = 1'b0;
        bus.i_ex_ready = 1'b0;
        bus.i_wb_rd_wren = 1'b1; bus.i_wb_rd_addr = 5'd6; bus.i_wb_rd_data = 32'h0000_1234;
        #1;
        check_eq("stall_c1", bus.o_ex_operand_a, FWD ? 32'h1234 : 32'h11);
        tick();
        bus.i_wb_rd_wren = 1'b0;
        #1;
        check_eq("stall_c2", bus.o_ex_operand_a, FWD ? 32'h1234 : 32'h11);
        tick();
        check_eq("stall_c3", bus.o_ex_operand_a, FWD ? 32'h1234 : 32'h11);
        check_eq("stall_valid", 32'(bus.o_ex_valid), 32'd1);

        // New instruction offered during the stall is not accepted.
        present(5'd1, 32'h0000_0077, 5'd0, 32'h0, 32'h0, 1'b0, 5'd4, ALU_XOR);
        #1;
        check_eq("stall_noacc_rdy", 32'(bus.o_id_ready), 32'd0);
        tick();
        check_eq("stall_noacc_opa", bus.o_ex_operand_a, FWD ? 32'h1234 : 32'h11);

        // Back-to-back transfers with no bubble.
        bus.i_ex_ready = 1'b1;
        tick();
        check_eq("b2b1_valid", 32'(bus.o_ex_valid), 32'd1);
        check_eq("b2b1_opa", bus.o_ex_operand_a, 32'h77);
        check_eq("b2b1_aluop", 32'(bus.o_ex_alu_op), 32'(ALU_XOR));
        bus.i_id_rs1_data = 32'h0000_0088;
        tick();
        check_eq("b2b2_valid", 32'(bus.o_ex_valid), 32'd1);
        check_eq("b2b2_opa", bus.o_ex_operand_a, 32'h88);

        // Flush with a valid decode instruction: nothing captured.
        bus.i_id_rs1_data = 32'h0000_0099;
        bus.i_flush = 1'b1;
        tick();
        check_eq("flush_valid", 32'(bus.o_ex_valid), 32'd0);
        check_eq("flush_nocap", bus.o_ex_operand_a, 32'h88);
        bus.i_flush = 1'b0;

        // Flush of a stalled held instruction.
        tick();
        bus.i_id_valid = 1'b0;
        bus.i_ex_ready = 1'b0;
        bus.i_flush    = 1'b1;
        tick();
        check_eq("flush_held", 32'(bus.o_ex_valid), 32'd0);
        bus.i_flush = 1'b0;

        // Reset arriving mid-stall.
        present(5'd2, 32'h0000_0055, 5'd3, 32'h0000_0066, 32'h0, 1'b0, 5'd8, ALU_SRA);
        bus.i_ex_ready = 1'b1;
        tick();
        bus.i_id_valid = 1'b0;
        bus.i_ex_ready = 1'b0;
        tick();
        check_eq("pre_rst_opb", bus.o_ex_operand_b, 32'h66);
        i_rst_n = 1'b0;
        tick();
        check_eq("mrst_valid", 32'(bus.o_ex_valid), 32'd0);
        check_eq("mrst_opa", bus.o_ex_operand_a, 32'h0);
        check_eq("mrst_opb", bus.o_ex_operand_b, 32'h0);
        check_eq("mrst_aluop", 32'(bus.o_ex_alu_op), 32'(ALU_ADD));
        i_rst_n = 1'b1;
        tick();
        check_eq("mrst_ready", 32'(bus.o_id_ready), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/idex_shift_stage.md
IDEX_SHIFT_STAGE -- requirements
Module: idex_shift_stage

Interface
REQ-001 i_clk  input  1  sole clock; all state updates on rising edge.
REQ-002 i_rst_n  input  1  reset, synchronous, active-low.
REQ-003 i_id_valid  input  1  decode presents an instruction.
REQ-004 o_id_ready  output  1  stage accepts the decode instruction this cycle.
REQ-005 i_id_rs1_data, i_id_rs2_data, i_id_imm  input  32 each  register-file operands and immediate.
REQ-006 i_id_rs1_addr, i_id_rs2_addr, i_id_rd_addr  input  5 each  source and destination register indices.
REQ-007 i_id_use_imm  input  1  operand B is taken from the immediate, not rs2.
REQ-008 i_id_alu_op  input  alu_op_e  operation code, carried through unchanged.
REQ-009 i_mem_rd_wren, i_mem_rd_addr (5), i_mem_rd_data (32)  input  MEM-stage writeback source.
REQ-010 i_wb_rd_wren, i_wb_rd_addr (5), i_wb_rd_data (32)  input  WB-stage writeback source.
REQ-011 i_flush  input  1  kill the held instruction.
REQ-012 o_ex_valid  output  1  EX holds a valid instruction.
REQ-013 i_ex_ready  input  1  EX consumes the instruction this cycle.
REQ-014 o_ex_operand_a, o_ex_operand_b  output  32 each  forwarded operands driving the ALU and shifters.
REQ-015 o_ex_shamt  output  5  equals o_ex_operand_b[4:0].
REQ-016 o_ex_rd_addr (5), o_ex_alu_op (alu_op_e)  output  carried fields.

Function
REQ-017 Pipeline register, one entry: o_id_ready = !o_ex_valid || i_ex_ready, combinational.
REQ-018 Load: when i_id_valid && o_id_ready && !i_flush, capture all ID fields and set o_ex_valid = 1 on the next edge, with latency 1.
REQ-019 Operand B source is i_id_imm if i_id_use_imm, else i_id_rs2_data; no forwarding on B when use_imm is set.
REQ-020 Consume without new load: when o_ex_valid && i_ex_ready && !(i_id_valid), clear o_ex_valid.
REQ-021 Flush takes priority over load and hold: o_ex_valid = 0 on the next edge; data registers are don't-care.
REQ-022 Forwarding is combinational on the registered rs addresses, applied to the outputs each cycle.
REQ-023 Forwarding priority is MEM, then WB, then the registered value.
REQ-024 A forwarding hit requires wren = 1 and an address match with rs_addr != 0.
REQ-025 x0 is never forwarded.
REQ-026 Stall refresh: while o_ex_valid && !i_ex_ready, each cycle write the forwarded operand value back into the held register, so a hit that later retires is not lost.
REQ-027 No forwarding into the capture path: the ID-stage register file is responsible for write-first bypass.
REQ-028 Simultaneous load and consume in one cycle is a back-to-back transfer with no bubble.

Reset
REQ-029 While i_rst_n = 0 at an edge: o_ex_valid = 0, all data registers = 0, o_ex_alu_op = ALU_ADD.
REQ-030 Reset overrides flush, load and refresh.
REQ-031 o_id_ready = 1 the first cycle after reset is released.

Configuration
REQ-032 Macro EX_FWD_EN, defined: forwarding and stall refresh per REQ-022 to REQ-026.
REQ-033 EX_FWD_EN undefined: operand outputs come directly from the held registers; MEM/WB inputs are ignored; the scoreboard guarantees no hazards.

Structure
REQ-034 Shared package riscv_pkg: XLEN = 32, REG_ADDR_W = 5, alu_op_e enum (ALU_ADD, ALU_SUB, ALU_SLL, ALU_SRL, ALU_SRA, ...).
REQ-035 One sub-module fwd_sel, instantiated once per operand: three-way priority select plus hit flag.

Verification
REQ-036 Load rs1 = 5, rs1_data = 0x0000_0001, imm = 0x0000_0004, use_imm = 1, ex_ready = 1 -> next cycle operand_a = 0x1, shamt = 4, ex_valid = 1.
REQ-037 Held rs1 = 5 and MEM write to r5 = 0xAAAA_0000 while WB writes r5 = 0x5555_0000 -> operand_a = 0xAAAA_0000.
REQ-038 rs1 = 0 with MEM write to r0 = 0xFFFF_FFFF -> operand_a = held value 0.
REQ-039 ex_ready = 0 for 3 cycles and WB hit r6 = 0x1234 in stall cycle 1 only -> operand_a stays 0x1234 through cycle 3 (EX_FWD_EN defined).
REQ-040 i_flush with i_id_valid = 1 in the same cycle -> ex_valid = 0 next cycle and no capture.
REQ-041 i_rst_n = 0 mid-stall -> ex_valid = 0 and operands = 0 next edge; id_ready = 1 after reset is released.
